// File: rtl/bin_2_bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bin_2_bcd_seq_converter
//
// Converts CHANNELS packed unsigned binary words into BCD, one channel at a
// time, by iterative shift-add-3 (double dabble). Used on the RTC display path
// between the DS1302 register unpacker and the 7-segment driver.
// Default use is ch0 = seconds, ch1 = minutes, ch2 = hours.
//
// Parameters
//   IN_W      binary width per channel (>=1)
//   DIGITS    BCD digits presented per channel (>=1)
//   CHANNELS  number of channels (>=1)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   bin_in is valid
//   in_ready   out  converter idle and able to accept a transfer
//   bin_in     in   CHANNELS*IN_W packed binary words, ch0 at the LSBs
//   out_valid  out  bcd_out/ovf hold a complete result
//   out_ready  in   consumer accepts the result
//   bcd_out    out  CHANNELS*DIGITS*4 packed BCD, ch0 at the LSBs,
//                   least-significant digit lowest within each slice
//   ovf        out  bit c set when channel c value >= 10**DIGITS
//
// Build option
//   BCD_SAT_EN  when defined, an overflowing channel reports all digits as 9;
//               otherwise it reports its low DIGITS digits (truncated).
// -----------------------------------------------------------------------------
module bin_2_bcd_seq_converter #(
  parameter int IN_W     = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_W-1:0]     bin_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
  output logic [CHANNELS-1:0]          ovf
);

  // Enough internal digits to hold 2**IN_W-1 (8**k < 10**k).
  localparam int INT_D = (IN_W + 2) / 3;
  localparam int SW    = INT_D*4 + IN_W;
  localparam int DW    = DIGITS*4;
  localparam int PD    = (INT_D > DIGITS) ? INT_D : DIGITS;
  localparam int PW    = PD*4;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW    = $clog2(IN_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   r_state;
  logic [CW-1:0]                r_ch_idx;
  logic [NW-1:0]                r_cnt;
  logic                         r_out_valid;
  logic [CHANNELS*DW-1:0]       r_bcd;
  logic [CHANNELS-1:0]          r_ovf;
  logic [CHANNELS*IN_W-1:0]     r_bin;
  logic [SW-1:0]                r_sreg;

  logic [PW-1:0]                w_pad;
  logic [DW-1:0]                w_low;
  logic [DW-1:0]                w_res;
  logic                         w_ovf;

  // One double-dabble iteration: correct every digit >= 5, then shift left.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int d = 0; d < INT_D; d++) begin
      if (t[IN_W+4*d +: 4] >= 4'd5)
        t[IN_W+4*d +: 4] = t[IN_W+4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // All-nines pattern substituted for an overflowing channel.
  function automatic logic [DW-1:0] sat_nines(input logic [DW-1:0] d, input logic of);
    logic [DW-1:0] n;
    for (int i = 0; i < DIGITS; i++) n[4*i +: 4] = 4'd9;
    return of ? n : d;
  endfunction

  // Digits of the finished channel, zero-padded up to whichever of
  // INT_D/DIGITS is larger so both the low slice and the overflow test
  // are always in range.
  always_comb begin
    w_pad = '0;
    w_pad[INT_D*4-1:0] = r_sreg[SW-1:IN_W];
  end

  assign w_low = w_pad[DW-1:0];

  generate
    if (PD > DIGITS) begin : g_ovf
      assign w_ovf = |w_pad[PW-1:DW];
    end else begin : g_no_ovf
      assign w_ovf = 1'b0;
    end
  endgenerate

`ifdef BCD_SAT_EN
  assign w_res = sat_nines(w_low, w_ovf);
`else
  assign w_res = w_low;
`endif

  // Control and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_idx    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ch_idx <= '0;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == NW'(IN_W-1)) r_state <= S_STORE;
        end
        S_STORE: begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (r_ch_idx == CW'(c)) begin
              r_bcd[c*DW +: DW] <= w_res;
              r_ovf[c]          <= w_ovf;
            end
          end
          if (r_ch_idx == CW'(CHANNELS-1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_ch_idx <= r_ch_idx + 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latched inputs and the shift register need no reset.
  // Channels are consumed from the LSBs of r_bin, which shifts down per load.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE:  if (in_valid) r_bin <= bin_in;
      S_LOAD: begin
        r_sreg <= {{(INT_D*4){1'b0}}, r_bin[IN_W-1:0]};
        r_bin  <= r_bin >> IN_W;
      end
      S_SHIFT: r_sreg <= dd_step(r_sreg);
      default: ;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign bcd_out   = r_bcd;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin_2_bcd_seq_converter.sv
`timescale 1ns/1ps
module tb_bin_2_bcd_seq_converter;

  localparam int IN_W  = 6;
  localparam int CH    = 3;
  localparam int LAT   = CH*(IN_W+2);
  localparam int B_LAT = 1*(8+2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [17:0] a_bin;
  logic [23:0] a_bcd;
  logic [2:0]  a_ovf;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_bin;
  logic [7:0]  b_bcd;
  logic [0:0]  b_ovf;

  bin_2_bcd_seq_converter #(.IN_W(6), .DIGITS(2), .CHANNELS(3)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .bin_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd_out(a_bcd), .ovf(a_ovf));

  bin_2_bcd_seq_converter #(.IN_W(8), .DIGITS(2), .CHANNELS(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .bin_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd_out(b_bcd), .ovf(b_ovf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input int v, output logic [7:0] bcd, output logic of);
    of  = (v >= 100);
    bcd = {4'((v/10)%10), 4'(v%10)};
`ifdef BCD_SAT_EN
    if (of) bcd = 8'h99;
`endif
  endfunction

  typedef struct packed {
    logic [23:0] bcd;
    logic [2:0]  ovf;
  } exp_t;

  function automatic exp_t exp_a(input int h, input int m, input int s);
    exp_t e;
    logic [7:0] b;
    logic o;
    model(s, b, o); e.bcd[7:0]   = b; e.ovf[0] = o;
    model(m, b, o); e.bcd[15:8]  = b; e.ovf[1] = o;
    model(h, b, o); e.bcd[23:16] = b; e.ovf[2] = o;
    return e;
  endfunction

  exp_t q[$];
  int   acc_times[$];
  int   cyc = 0;
  int   t_acc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  // Scoreboard: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    exp_t e;
    if (a_out_valid && !prev_v) chk("latency", 32'(cyc - t_acc), 32'(LAT));
    prev_v = a_out_valid;
    if (a_out_valid && a_out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got bcd %0h with no transfer pending", a_bcd);
      end else begin
        e = q.pop_front();
        chk("bcd_out", 32'(a_bcd), 32'(e.bcd));
        chk("ovf", 32'(a_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic send_a(input logic [17:0] bin, input exp_t e);
    int n = 0;
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_bin      = bin;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready %0b required 1", a_in_ready);
      a_in_valid = 1'b0;
      return;
    end
    q.push_back(e);
    @(posedge clk); #1;
    t_acc = cyc;
    acc_times.push_back(cyc);
    a_in_valid = 1'b0;
    a_bin      = 18'($urandom);
  endtask

  task automatic drain_a();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic run_b(input logic [7:0] bin, input logic [7:0] exp_bcd, input logic exp_ovf);
    int n = 0;
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    b_bin      = bin;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_bin      = 8'($urandom);
    while (!b_out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_latency", 32'(n), 32'(B_LAT));
    chk("b_bcd_out", 32'(b_bcd), 32'(exp_bcd));
    chk("b_ovf", 32'(b_ovf), 32'(exp_ovf));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_valid_drop", 32'(b_out_valid), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  h, m, s;
    logic [23:0] bcd;
  } vec_a_t;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] bcd;
    logic       ovf;
  } vec_b_t;

`ifdef BCD_SAT_EN
  localparam logic [7:0] R142 = 8'h99, R255 = 8'h99, R100 = 8'h99;
`else
  localparam logic [7:0] R142 = 8'h42, R255 = 8'h55, R100 = 8'h00;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_a_t ta[6];
    vec_b_t tb[5];
    exp_t   e;

    ta[0] = '{6'd23, 6'd59, 6'd7,  24'h235907};
    ta[1] = '{6'd0,  6'd0,  6'd0,  24'h000000};
    ta[2] = '{6'd63, 6'd63, 6'd63, 24'h636363};
    ta[3] = '{6'd12, 6'd34, 6'd56, 24'h123456};
    ta[4] = '{6'd9,  6'd10, 6'd19, 24'h091019};
    ta[5] = '{6'd50, 6'd5,  6'd40, 24'h500540};
    tb[0] = '{8'd142, R142,  1'b1};
    tb[1] = '{8'd99,  8'h99, 1'b0};
    tb[2] = '{8'd255, R255,  1'b1};
    tb[3] = '{8'd100, R100,  1'b1};
    tb[4] = '{8'd0,   8'h00, 1'b0};

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_bcd_out", 32'(a_bcd), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(a_in_ready), 32'd1);

    // Hand-picked vectors, including all-zero and maximum inputs
    for (int i = 0; i < 6; i++) begin
      e.bcd = ta[i].bcd;
      e.ovf = 3'b000;
      send_a({ta[i].h, ta[i].m, ta[i].s}, e);
    end
    drain_a();

    // Every value 0..63 appears on every channel
    for (int v = 0; v < 64; v++) begin
      int s, m, h;
      s = v; m = (v + 21) % 64; h = (v + 42) % 64;
      send_a({6'(h), 6'(m), 6'(s)}, exp_a(h, m, s));
    end
    drain_a();

    // Consumer stalls in DONE: result holds, new requests are refused
    a_out_ready = 1'b0;
    e.bcd = 24'h471138; e.ovf = 3'b000;
    send_a({6'd47, 6'd11, 6'd38}, e);
    begin
      int n = 0;
      while (!a_out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a_in_valid = i[0];
      a_bin      = 18'($urandom);
      @(negedge clk);
      chk("stall_out_valid", 32'(a_out_valid), 32'd1);
      chk("stall_bcd_out", 32'(a_bcd), 32'h471138);
      chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    end
    @(posedge clk); #1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    drain_a();
    repeat (30) @(posedge clk);
    #1;
    chk("no_phantom_output", 32'(a_out_valid), 32'd0);
    chk("post_stall_bcd_hold", 32'(a_bcd), 32'h471138);

    // Reset in the middle of a conversion
    e.bcd = 24'h403020; e.ovf = 3'b000;
    send_a({6'd40, 6'd30, 6'd20}, e);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    chk("abort_out_valid", 32'(a_out_valid), 32'd0);
    chk("abort_bcd_out", 32'(a_bcd), 32'd0);
    chk("abort_ovf", 32'(a_ovf), 32'd0);
    chk("abort_in_ready", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    e.bcd = 24'h010203; e.ovf = 3'b000;
    send_a({6'd1, 6'd2, 6'd3}, e);
    drain_a();

    // Back-to-back transfers
    acc_times.delete();
    for (int i = 0; i < 8; i++) begin
      int s, m, h;
      s = $urandom_range(0, 63); m = $urandom_range(0, 63); h = $urandom_range(0, 63);
      send_a({6'(h), 6'(m), 6'(s)}, exp_a(h, m, s));
    end
    drain_a();
    for (int i = 1; i < acc_times.size(); i++) begin
      int d;
      d = acc_times[i] - acc_times[i-1];
      checks++;
      if (d < LAT + 1 || d > LAT + 2) begin
        errors++;
        $display("FAIL accept_spacing: got %0d clocks, required %0d..%0d", d, LAT + 1, LAT + 2);
      end
    end

    // Wide input with too few output digits
    for (int i = 0; i < 5; i++) run_b(tb[i].bin, tb[i].bcd, tb[i].ovf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
